// File: rtl/axis_hdr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axis_hdr_pkg
//  Description : Shared state encoding and header width derivations for the
//                header arbiter and the header inserter it feeds.
//  Revision    : 1.0 - initial release
// ============================================================================
package axis_hdr_pkg;

    localparam int C_DEF_DATA_WD = 32;
    localparam int C_DEF_NUM_SRC = 4;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_OFFER     = 2'd1,
        ST_WAIT_DONE = 2'd2
    } state_t;

    // Bytes per header word.
    function automatic int byte_wd(input int data_wd);
        return data_wd / 8;
    endfunction

    // Width of the header byte-count field.
    function automatic int cnt_wd(input int data_wd);
        return $clog2(data_wd / 8);
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_stream_header_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : axi_stream_header_arbiter_if
//  Description : Producer-side header requests, inserter-side header channel
//                and status signals of the header arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface axi_stream_header_arbiter_if
    import axis_hdr_pkg::*;
#(
    parameter int DATA_WD      = C_DEF_DATA_WD,
    parameter int DATA_BYTE_WD = byte_wd(DATA_WD),
    parameter int BYTE_CNT_WD  = cnt_wd(DATA_WD),
    parameter int NUM_SRC      = C_DEF_NUM_SRC,
    parameter int SRC_ID_WD    = $clog2(NUM_SRC)
);
    logic [NUM_SRC-1:0]              valid_hdr;
    logic [NUM_SRC*DATA_WD-1:0]      data_hdr;
    logic [NUM_SRC*DATA_BYTE_WD-1:0] keep_hdr;
    logic [NUM_SRC*BYTE_CNT_WD-1:0]  cnt_hdr;
    logic [NUM_SRC-1:0]              ready_hdr;
    logic                            valid_insert;
    logic [DATA_WD-1:0]              data_insert;
    logic [DATA_BYTE_WD-1:0]         keep_insert;
    logic [BYTE_CNT_WD-1:0]          byte_insert_cnt;
    logic                            ready_insert;
    logic                            pkt_done;
    logic [SRC_ID_WD-1:0]            grant_id;
    logic                            busy;
    logic                            err_done;

    // Arbiter view.
    modport slave (
        input  valid_hdr, data_hdr, keep_hdr, cnt_hdr, ready_insert, pkt_done,
        output ready_hdr, valid_insert, data_insert, keep_insert,
               byte_insert_cnt, grant_id, busy, err_done
    );

    // Environment view (producers + inserter).
    modport master (
        output valid_hdr, data_hdr, keep_hdr, cnt_hdr, ready_insert, pkt_done,
        input  ready_hdr, valid_insert, data_insert, keep_insert,
               byte_insert_cnt, grant_id, busy, err_done
    );
endinterface
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin pick. The request vector is
//                doubled and shifted by the pointer so the first set bit of
//                the low half is the winner; the pointer is owned by the
//                parent so it only advances on an accepted grant.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N      = 4,
    parameter int IDX_WD = $clog2(N)
) (
    input  logic [N-1:0]      req,
    input  logic [IDX_WD-1:0] ptr,
    output logic [N-1:0]      gnt,
    output logic [IDX_WD-1:0] gnt_idx,
    output logic              any
);
    logic [2*N-1:0]    w_dbl;
    logic [N-1:0]      w_rot;
    logic [IDX_WD-1:0] w_off;
    logic [IDX_WD:0]   w_sum;

    assign w_dbl = {req, req};
    assign w_rot = N'(w_dbl >> ptr);
    assign any   = |req;

    // Lowest set bit of the rotated request is the offset from the pointer.
    always_comb begin
        w_off = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = IDX_WD'(i);
            end
        end
    end

    assign w_sum   = {1'b0, ptr} + {1'b0, w_off};
    assign gnt_idx = (w_sum >= (IDX_WD+1)'(N)) ? IDX_WD'(w_sum - (IDX_WD+1)'(N))
                                               : w_sum[IDX_WD-1:0];

    // One-hot grant, all-zero when nothing requests.
    always_comb begin
        gnt          = '0;
        gnt[gnt_idx] = any;
    end
endmodule
`default_nettype wire

// File: rtl/axi_stream_header_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : axi_stream_header_arbiter
//  Description : Round-robin header scheduler in front of the header
//                inserter. Offers one header at a time and waits for the
//                carrying packet to leave before granting the next.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_stream_header_arbiter
    import axis_hdr_pkg::*;
#(
    parameter int DATA_WD      = C_DEF_DATA_WD,
    parameter int DATA_BYTE_WD = byte_wd(DATA_WD),
    parameter int BYTE_CNT_WD  = cnt_wd(DATA_WD),
    parameter int NUM_SRC      = C_DEF_NUM_SRC,
    parameter int SRC_ID_WD    = $clog2(NUM_SRC)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    axi_stream_header_arbiter_if.slave   bus
);
    state_t                  r_state;
    state_t                  w_next_state;
    logic [SRC_ID_WD-1:0]    r_rr_ptr;
    logic [SRC_ID_WD-1:0]    w_gnt_idx;
    logic [SRC_ID_WD-1:0]    w_ptr_next;
    logic [NUM_SRC-1:0]      w_gnt;
    logic                    w_any;
    logic                    w_accept;
    logic [DATA_WD-1:0]      w_sel_data;
    logic [DATA_BYTE_WD-1:0] w_sel_keep;
    logic [BYTE_CNT_WD-1:0]  w_sel_cnt;

    logic [DATA_WD-1:0]      r_data;
    logic [DATA_BYTE_WD-1:0] r_keep;
    logic [BYTE_CNT_WD-1:0]  r_cnt;
    logic [SRC_ID_WD-1:0]    r_grant_id;
    logic                    r_valid;
    logic                    r_busy;
    logic                    r_err;

    rr_arbiter #(
        .N      (NUM_SRC),
        .IDX_WD (SRC_ID_WD)
    ) u_rr_arbiter (
        .req     (bus.valid_hdr),
        .ptr     (r_rr_ptr),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx),
        .any     (w_any)
    );

    // Payload of the currently picked source.
    assign w_sel_data = bus.data_hdr[int'(w_gnt_idx)*DATA_WD +: DATA_WD];
    assign w_sel_keep = bus.keep_hdr[int'(w_gnt_idx)*DATA_BYTE_WD +: DATA_BYTE_WD];
    assign w_sel_cnt  = bus.cnt_hdr[int'(w_gnt_idx)*BYTE_CNT_WD +: BYTE_CNT_WD];
    assign w_ptr_next = (w_gnt_idx == SRC_ID_WD'(NUM_SRC - 1)) ? '0
                                                              : w_gnt_idx + SRC_ID_WD'(1);

    // Source accept is combinational and only legal in IDLE outside reset.
    assign bus.ready_hdr = (r_state == ST_IDLE && rst_n) ? w_gnt : '0;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; an OFFER handshake wins over a coincident pkt_done.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_accept     = 1'b1;
                    w_next_state = ST_OFFER;
                end
            end
            ST_OFFER: begin
                if (r_valid && bus.ready_insert) begin
                    w_next_state = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (bus.pkt_done) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Granted header capture, pointer advance and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr   <= '0;
            r_data     <= '0;
            r_keep     <= '0;
            r_cnt      <= '0;
            r_grant_id <= '0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_data     <= w_sel_data;
                r_keep     <= w_sel_keep;
                r_cnt      <= w_sel_cnt;
                r_grant_id <= w_gnt_idx;
                r_rr_ptr   <= w_ptr_next;
            end
            r_valid <= (w_next_state == ST_OFFER);
            r_busy  <= (w_next_state != ST_IDLE);
            if (bus.pkt_done && r_state != ST_WAIT_DONE) begin
                r_err <= 1'b1;
            end
        end
    end

    assign bus.valid_insert    = r_valid;
    assign bus.data_insert     = r_data;
    assign bus.keep_insert     = r_keep;
    assign bus.byte_insert_cnt = r_cnt;
    assign bus.grant_id        = r_grant_id;
    assign bus.busy            = r_busy;
    assign bus.err_done        = r_err;
endmodule
`default_nettype wire

// File: tb/tb_axi_stream_header_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_stream_header_arbiter
//  Description : Directed vector bench for the header arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_stream_header_arbiter;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    axi_stream_header_arbiter_if #(.DATA_WD(32), .NUM_SRC(4)) bus ();

    axi_stream_header_arbiter #(.DATA_WD(32), .NUM_SRC(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [31:0] sd [4];
    logic [3:0]  sk [4];
    logic [1:0]  sc [4];

    assign bus.data_hdr = {sd[3], sd[2], sd[1], sd[0]};
    assign bus.keep_hdr = {sk[3], sk[2], sk[1], sk[0]};
    assign bus.cnt_hdr  = {sc[3], sc[2], sc[1], sc[0]};

    typedef struct {
        logic [3:0] vh;
        logic       ri;
        logic       pd;
        logic [3:0] e_rdy;
        logic       e_vi;
        logic [1:0] e_gid;
        logic       e_busy;
        logic       e_err;
    } vec_t;

    vec_t tbl[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // One packet: IDLE grant, OFFER handshake, pkt_done in WAIT_DONE.
    function automatic void add_pkt(input logic [3:0] vh, input logic [1:0] gid);
        logic [3:0] oh;
        oh = 4'b0001 << gid;
        tbl.push_back('{vh, 1'b0, 1'b0, oh,    1'b1, gid, 1'b1, 1'b0});
        tbl.push_back('{vh, 1'b1, 1'b0, 4'h0,  1'b0, gid, 1'b1, 1'b0});
        tbl.push_back('{vh, 1'b0, 1'b1, 4'h0,  1'b0, gid, 1'b0, 1'b0});
    endfunction

    task automatic step(input logic [3:0] vh, input logic ri, input logic pd,
                        input logic [3:0] e_rdy, input string nm);
        @(negedge clk);
        bus.valid_hdr    = vh;
        bus.ready_insert = ri;
        bus.pkt_done     = pd;
        #1 chk({nm, ".ready_hdr"}, 32'(bus.ready_hdr), 32'(e_rdy));
        @(posedge clk);
        #1;
    endtask

    task automatic regs(input string nm, input logic e_vi, input logic [1:0] e_gid,
                        input logic e_busy, input logic e_err);
        chk({nm, ".valid_insert"}, 32'(bus.valid_insert), 32'(e_vi));
        chk({nm, ".grant_id"},     32'(bus.grant_id),     32'(e_gid));
        chk({nm, ".busy"},         32'(bus.busy),         32'(e_busy));
        chk({nm, ".err_done"},     32'(bus.err_done),     32'(e_err));
    endtask

    task automatic pay(input string nm, input logic [31:0] d, input logic [3:0] k,
                       input logic [1:0] c);
        chk({nm, ".data_insert"},     bus.data_insert,            d);
        chk({nm, ".keep_insert"},     32'(bus.keep_insert),       32'(k));
        chk({nm, ".byte_insert_cnt"}, 32'(bus.byte_insert_cnt),   32'(c));
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, ".ready_hdr"}, 32'(bus.ready_hdr), 32'h0);
        regs(nm, 1'b0, 2'd0, 1'b0, 1'b0);
        pay(nm, 32'h0, 4'h0, 2'd0);
    endtask

    // Mid-cycle asynchronous reset with requests pending.
    task automatic async_reset(input string nm);
        #2;
        rst_n         = 1'b0;
        bus.valid_hdr = 4'b1111;
        #1 chk_zero(nm);
        @(negedge clk);
        bus.valid_hdr = 4'b0000;
        rst_n         = 1'b1;
    endtask

    initial begin
        sd[0] = 32'h1111_0000; sk[0] = 4'b1111; sc[0] = 2'd0;
        sd[1] = 32'h2222_0001; sk[1] = 4'b0111; sc[1] = 2'd1;
        sd[2] = 32'h3333_0002; sk[2] = 4'b0011; sc[2] = 2'd2;
        sd[3] = 32'h4444_0003; sk[3] = 4'b0001; sc[3] = 2'd3;
        bus.valid_hdr    = 4'b1111;
        bus.ready_insert = 1'b0;
        bus.pkt_done     = 1'b0;

        for (int i = 0; i < 8; i++) add_pkt(4'b1111, 2'(i % 4));
        add_pkt(4'b0001, 2'd0);
        add_pkt(4'b1001, 2'd3);
        add_pkt(4'b1001, 2'd0);
        add_pkt(4'b1001, 2'd3);
        tbl.push_back('{4'b0000, 1'b0, 1'b0, 4'h0, 1'b0, 2'd3, 1'b0, 1'b0});

        // Power-on reset with all sources requesting.
        repeat (2) @(negedge clk);
        chk_zero("por");
        bus.valid_hdr = 4'b0000;
        rst_n         = 1'b1;

        // Fairness and idle-source skipping.
        for (int k = 0; k < tbl.size(); k++) begin
            string nm;
            nm = $sformatf("vec%0d", k);
            step(tbl[k].vh, tbl[k].ri, tbl[k].pd, tbl[k].e_rdy, nm);
            regs(nm, tbl[k].e_vi, tbl[k].e_gid, tbl[k].e_busy, tbl[k].e_err);
            if (tbl[k].e_vi) pay(nm, sd[tbl[k].e_gid], sk[tbl[k].e_gid], sc[tbl[k].e_gid]);
        end

        // Reset mid-OFFER, then first grant after release.
        step(4'b1111, 1'b0, 1'b0, 4'b0001, "rst_offer");
        regs("rst_offer", 1'b1, 2'd0, 1'b1, 1'b0);
        async_reset("rst_offer_z");
        step(4'b0100, 1'b0, 1'b0, 4'b0100, "rst_rel");
        regs("rst_rel", 1'b1, 2'd2, 1'b1, 1'b0);
        pay("rst_rel", sd[2], sk[2], sc[2]);

        // Reset mid-WAIT_DONE with the pointer at 3: pointer restarts at 0.
        step(4'b0100, 1'b1, 1'b0, 4'b0000, "rst_wait");
        regs("rst_wait", 1'b0, 2'd2, 1'b1, 1'b0);
        async_reset("rst_wait_z");
        step(4'b1111, 1'b0, 1'b0, 4'b0001, "ptr_restart");
        regs("ptr_restart", 1'b1, 2'd0, 1'b1, 1'b0);
        step(4'b0000, 1'b1, 1'b0, 4'b0000, "ptr_restart_hs");
        step(4'b0000, 1'b0, 1'b1, 4'b0000, "ptr_restart_done");
        regs("ptr_restart_done", 1'b0, 2'd0, 1'b0, 1'b0);

        // Single source: one-cycle offer, silence until pkt_done, regrant at M+2.
        sd[1] = 32'hA1B2_C3D4; sk[1] = 4'b0111; sc[1] = 2'd3;
        step(4'b0010, 1'b1, 1'b0, 4'b0010, "single");
        regs("single", 1'b1, 2'd1, 1'b1, 1'b0);
        pay("single", 32'hA1B2_C3D4, 4'b0111, 2'd3);
        step(4'b0000, 1'b1, 1'b0, 4'b0000, "single_hs");
        regs("single_hs", 1'b0, 2'd1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(4'b0010, 1'b0, 1'b0, 4'b0000, "single_wait");
            regs("single_wait", 1'b0, 2'd1, 1'b1, 1'b0);
        end
        step(4'b0010, 1'b0, 1'b1, 4'b0000, "single_done");
        regs("single_done", 1'b0, 2'd1, 1'b0, 1'b0);
        step(4'b0010, 1'b0, 1'b0, 4'b0010, "single_regrant");
        regs("single_regrant", 1'b1, 2'd1, 1'b1, 1'b0);

        // Backpressure: ten cycles held in OFFER, handshake on the eleventh.
        for (int i = 0; i < 10; i++) begin
            step(4'b1111, 1'b0, 1'b0, 4'b0000, "bp_hold");
            regs("bp_hold", 1'b1, 2'd1, 1'b1, 1'b0);
            pay("bp_hold", 32'hA1B2_C3D4, 4'b0111, 2'd3);
        end
        step(4'b1111, 1'b1, 1'b0, 4'b0000, "bp_hs");
        regs("bp_hs", 1'b0, 2'd1, 1'b1, 1'b0);
        step(4'b0000, 1'b0, 1'b1, 4'b0000, "bp_done");
        regs("bp_done", 1'b0, 2'd1, 1'b0, 1'b0);

        // pkt_done in IDLE: sticky error, state stays IDLE (pointer at 2 -> src0).
        step(4'b0000, 1'b0, 1'b1, 4'b0000, "err_idle");
        regs("err_idle", 1'b0, 2'd1, 1'b0, 1'b1);
        step(4'b0001, 1'b0, 1'b0, 4'b0001, "err_idle_next");
        regs("err_idle_next", 1'b1, 2'd0, 1'b1, 1'b1);
        async_reset("err_clear");

        // pkt_done coinciding with the OFFER handshake: handshake wins, error set.
        step(4'b0001, 1'b0, 1'b0, 4'b0001, "err_offer");
        regs("err_offer", 1'b1, 2'd0, 1'b1, 1'b0);
        step(4'b0000, 1'b1, 1'b1, 4'b0000, "err_offer_hs");
        regs("err_offer_hs", 1'b0, 2'd0, 1'b1, 1'b1);
        step(4'b0000, 1'b0, 1'b0, 4'b0000, "err_offer_wait");
        regs("err_offer_wait", 1'b0, 2'd0, 1'b1, 1'b1);
        step(4'b0000, 1'b0, 1'b1, 4'b0000, "err_offer_done");
        regs("err_offer_done", 1'b0, 2'd0, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axi_stream_header_arbiter.md
# axi_stream_header_arbiter

Header-source scheduler placed in front of `axi_stream_insert_header`. It collects header requests from `NUM_SRC` independent producers and grants them round-robin. It presents exactly one header at a time on the inserter's `*_insert` channel. No new header is offered until the inserter reports that the packet carrying the current header has left its output (`last_out` handshake).

## Interface
Parameters:
- `DATA_WD`, 32, header/data word width in bits
- `DATA_BYTE_WD`, `DATA_WD/8`, bytes per word
- `BYTE_CNT_WD`, `$clog2(DATA_BYTE_WD)`, width of header byte count
- `NUM_SRC`, 4, number of header producers (≥2)
- `SRC_ID_WD`, `$clog2(NUM_SRC)`, width of grant index

Ports:
- `clk`  in  1  clock, all logic on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `valid_hdr`  in  `NUM_SRC`  per-source header valid
- `data_hdr`  in  `NUM_SRC*DATA_WD`  per-source header word; source i at bits [i*DATA_WD +: DATA_WD]
- `keep_hdr`  in  `NUM_SRC*DATA_BYTE_WD`  per-source header keep, same packing
- `cnt_hdr`  in  `NUM_SRC*BYTE_CNT_WD`  per-source header byte count, same packing
- `ready_hdr`  out  `NUM_SRC`  per-source header accept; one-hot or zero
- `valid_insert`  out  1  header valid to inserter
- `data_insert`  out  `DATA_WD`  granted header word
- `keep_insert`  out  `DATA_BYTE_WD`  granted header keep
- `byte_insert_cnt`  out  `BYTE_CNT_WD`  granted header byte count
- `ready_insert`  in  1  inserter header ready
- `pkt_done`  in  1  pulse = inserter `last_out & valid_out & ready_out`
- `grant_id`  out  `SRC_ID_WD`  index of source owning current packet
- `busy`  out  1  high in OFFER and WAIT_DONE
- `err_done`  out  1  sticky: `pkt_done` seen outside WAIT_DONE

## Operation
- States: IDLE, OFFER, WAIT_DONE.
- IDLE:
  - If any `valid_hdr` bit is set, pick the first set bit scanning upward from `rr_ptr` with wrap.
  - Drive `ready_hdr[pick]=1`. This is combinational from `valid_hdr`, is legal only in IDLE, and all other bits are 0.
  - Register `data/keep/cnt` of the pick and set `grant_id=pick`.
  - Set `rr_ptr = (pick+1) mod NUM_SRC`, then go to OFFER.
- OFFER:
  - `valid_insert=1`; `data_insert`, `keep_insert` and `byte_insert_cnt` are held stable.
  - On `valid_insert & ready_insert`, go to WAIT_DONE.
- WAIT_DONE:
  - `valid_insert=0`; `ready_hdr=0`.
  - On `pkt_done`, go to IDLE.
- `err_done` is set when `pkt_done=1` in IDLE or OFFER. State is unaffected, and the bit clears only on reset.
- Requests from non-granted sources wait, with their `valid_hdr` held by the producer. No request is dropped.
- With all sources continuously requesting, the grant order is 0,1,2,3,0,…

## Timing
- Reset values:
  - state IDLE, `rr_ptr=0`
  - `ready_hdr=0` while `rst_n=0`
  - `valid_insert=0`, `data_insert=0`, `keep_insert=0`, `byte_insert_cnt=0`
  - `grant_id=0`, `busy=0`, `err_done=0`
- Latency:
  - Source handshake in cycle N → `valid_insert=1` in N+1.
  - `pkt_done` in cycle M → IDLE in M+1, so the earliest next source handshake is M+1.
  - The next header appears on `valid_insert` at M+2.
- All outputs except `ready_hdr` are registered.
- `pkt_done` in the same cycle as the OFFER handshake: the handshake wins (go to WAIT_DONE) and `err_done` is set.
- `ready_insert` low indefinitely: remain in OFFER with payload stable. No timeout.
- A source dropping `valid_hdr` before its `ready_hdr` is a protocol violation and is not checked.
- Asynchronous reset mid-OFFER or mid-WAIT_DONE:
  - Immediate return to reset values.
  - The granted header is discarded and the inserter must be reset in the same domain.
  - `rr_ptr` restarts at 0.

## Structure
- Shared package/include `axis_hdr_pkg`:
  - state encoding (IDLE=0, OFFER=1, WAIT_DONE=2, 2-bit)
  - header word/keep/count width derivations reused by `axi_stream_insert_header`
- Sub-module `rr_arbiter`:
  - Parameter `N`.
  - Inputs: `req[N]`, `ptr`.
  - Outputs: one-hot `gnt[N]`, `gnt_idx`, `any`.
  - Purely combinational, using a doubled-request priority scan.
  - The pointer register lives in the parent so the update happens only on an accepted grant.
- Expected top-level size: about 200 lines.

## Test plan
1. **Reset:** assert `rst_n=0` mid-run → all outputs 0 immediately; after release with `valid_hdr=4'b0100` → `ready_hdr=4'b0100` at first edge, `grant_id=2`, `valid_insert` next cycle.
2. **Single source:** src1 header `data=32'hA1B2C3D4`, `keep=4'b0111`, `cnt=3`; `ready_insert=1` → `data_insert=32'hA1B2C3D4`, `byte_insert_cnt=3` for exactly one cycle; no further `valid_insert` until `pkt_done`; next `valid_insert` two cycles after `pkt_done`.
3. **Fairness:** `valid_hdr=4'b1111` held across 8 packets → `grant_id` sequence 0,1,2,3,0,1,2,3.
4. **Skip idle sources:** `valid_hdr=4'b1001`, `rr_ptr=1` → grant 3, then 0, then 3.
5. **Backpressure:** `ready_insert=0` for 10 cycles in OFFER → `valid_insert` and payload unchanged; `ready_hdr=0` throughout; handshake on the 11th cycle → WAIT_DONE.
6. **Protocol errors:** `pkt_done` pulse in IDLE → `err_done=1` next cycle, state still IDLE; `pkt_done` coinciding with the OFFER handshake → WAIT_DONE and `err_done=1`.
